// File: rtl/sr_param_playback.sv
// Replays buffered 5-harmonic omega_dt records into the oscillator bank, one record per SAMPLE_DIVISOR clk_en.
// Optional build macro SR_PLAYBACK_SLEW_EN: outputs slew toward loaded targets by SLEW_STEP per clk_en.
module sr_param_playback #(
    parameter int WIDTH          = 18,
    parameter int SAMPLE_DIVISOR = 4000,
    parameter int FIFO_DEPTH     = 4,
    parameter int NOM_F0         = 199,
    parameter int NOM_F1         = 354,
    parameter int NOM_F2         = 514,
    parameter int NOM_F3         = 643,
    parameter int NOM_F4         = 823,
    parameter int SLEW_STEP      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 enable,
    input  logic                 rec_valid,
    output logic                 rec_ready,
    input  logic [5*WIDTH-1:0]   rec_data,
    output logic [5*WIDTH-1:0]   omega_dt_packed,
    output logic                 frame_tick,
    output logic                 playing,
    output logic [15:0]          underrun_count,
    output logic [31:0]          record_count
);

    localparam int DW   = 5 * WIDTH;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int DIVW = (SAMPLE_DIVISOR > 1) ? $clog2(SAMPLE_DIVISOR) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIVISOR - 1);
    localparam logic [DW-1:0] NOM_PACKED = {WIDTH'(NOM_F4), WIDTH'(NOM_F3), WIDTH'(NOM_F2),
                                            WIDTH'(NOM_F1), WIDTH'(NOM_F0)};

    if (SLEW_STEP < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("sr_param_playback: invalid SLEW_STEP or FIFO_DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_r, state_next_s;
    logic [DIVW-1:0]   div_r, div_next_s;
    logic              apply_s, underrun_s;

    logic [DW-1:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              full_s, empty_s, push_s;
    logic [DW-1:0]     head_s;

    logic [DW-1:0]     omega_r;
    logic              frame_tick_r, playing_r;
    logic [15:0]       underrun_r;
    logic [31:0]       record_r;

    // Ready reflects the pre-pop occupancy, so a push is never taken while full.
    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign push_s    = rec_valid && !full_s;
    assign head_s    = mem_r[rd_ptr_r];
    assign rec_ready = !full_s;

    // Record storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rec_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (apply_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, apply_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Playback state and frame divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            div_r   <= {DIVW{1'b0}};
        end else begin
            state_r <= state_next_s;
            div_r   <= div_next_s;
        end
    end

    // Next-state logic; only the enable check acts without clk_en.
    always_comb begin
        state_next_s = state_r;
        div_next_s   = div_r;
        apply_s      = 1'b0;
        underrun_s   = 1'b0;
        if (!enable) begin
            state_next_s = IDLE;
            div_next_s   = {DIVW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = PRIME;
                end
                PRIME, HOLD: begin
                    // Restarting from HOLD realigns the frame phase to the late record.
                    if (clk_en && !empty_s) begin
                        apply_s      = 1'b1;
                        div_next_s   = {DIVW{1'b0}};
                        state_next_s = PLAY;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                PLAY: begin
                    if (clk_en && (div_r == DIV_LAST)) begin
                        div_next_s = {DIVW{1'b0}};
                        if (!empty_s) begin
                            apply_s = 1'b1;
                        end else begin
                            underrun_s   = 1'b1;
                            state_next_s = HOLD;
                        end
                    end else if (clk_en) begin
                        div_next_s = div_r + DIVW'(1);
                    end else begin
                        div_next_s = div_r;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    div_next_s   = {DIVW{1'b0}};
                end
            endcase
        end
    end

    // Status outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick_r <= 1'b0;
            playing_r    <= 1'b0;
            underrun_r   <= 16'h0000;
            record_r     <= 32'h0000_0000;
        end else begin
            frame_tick_r <= apply_s;
            playing_r    <= (state_next_s == PLAY);
            if (underrun_s && (underrun_r != 16'hFFFF)) begin
                underrun_r <= underrun_r + 16'h0001;
            end
            if (apply_s) begin
                record_r <= record_r + 32'h0000_0001;
            end
        end
    end

`ifdef SR_PLAYBACK_SLEW_EN
    localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(SLEW_STEP);

    // Moves one signed harmonic toward its target by at most SLEW_STEP.
    function automatic logic [WIDTH-1:0] slew_word(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
        logic signed [WIDTH:0] diff;
        logic [WIDTH-1:0]      res;
        diff = $signed({tgt[WIDTH-1], tgt}) - $signed({cur[WIDTH-1], cur});
        if (diff > STEP_S) begin
            res = cur + WIDTH'(SLEW_STEP);
        end else if (diff < -STEP_S) begin
            res = cur - WIDTH'(SLEW_STEP);
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    logic [DW-1:0] target_r;

    // Applied records load targets; outputs slew toward them on each clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= NOM_PACKED;
            omega_r  <= NOM_PACKED;
        end else begin
            if (apply_s) begin
                target_r <= head_s;
            end
            if (clk_en) begin
                for (int h = 0; h < 5; h++) begin
                    omega_r[h*WIDTH +: WIDTH] <= slew_word(omega_r[h*WIDTH +: WIDTH],
                                                           target_r[h*WIDTH +: WIDTH]);
                end
            end
        end
    end
`else
    // Applied records drive the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            omega_r <= NOM_PACKED;
        end else if (apply_s) begin
            omega_r <= head_s;
        end else begin
            omega_r <= omega_r;
        end
    end
`endif

    assign omega_dt_packed = omega_r;
    assign frame_tick      = frame_tick_r;
    assign playing         = playing_r;
    assign underrun_count  = underrun_r;
    assign record_count    = record_r;

endmodule

// File: tb/tb_sr_param_playback.sv
// Bench for sr_param_playback: vector table, hand-written corner sequences, randomized run against a queue model.
module tb_sr_param_playback;

    localparam int W     = 18;
    localparam int SD    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 5 * W;

    logic          clk = 1'b0;
    logic          rst_n, clk_en, enable, rec_valid, rec_ready;
    logic [DW-1:0] rec_data, omega_dt_packed;
    logic          frame_tick, playing;
    logic [15:0]   underrun_count;
    logic [31:0]   record_count;

    sr_param_playback #(.WIDTH(W), .SAMPLE_DIVISOR(SD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .enable(enable),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .omega_dt_packed(omega_dt_packed), .frame_tick(frame_tick), .playing(playing),
        .underrun_count(underrun_count), .record_count(record_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rec(input int k);
        return {W'(k * 7), W'(5), W'(-(k + 1)), W'(2000 + k), W'(1000 + k)};
    endfunction

    typedef struct {
        logic en, ce, v;
        int   rid;
        logic ready, tick, play;
        int   h0;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] nom;

    // Reference model state
    logic [DW-1:0] mq[$];
    int            mmode;   // 0 stopped, 1 awaiting first record, 2 playing, 3 starved
    int            mticks;
    logic [DW-1:0] mout;
    logic          mtick;
    int            munder;
    logic [31:0]   mrec;

    task automatic model_step(input logic en, input logic ce, input logic v, input logic [DW-1:0] d);
        bit can_pop, acc;
        can_pop = (mq.size() > 0);
        acc     = v && (mq.size() < DEPTH);
        mtick   = 1'b0;
        if (!en) begin
            mmode  = 0;
            mticks = 0;
        end else if (mmode == 0) begin
            mmode = 1;
        end else if (ce && (mmode == 1 || mmode == 3)) begin
            if (can_pop) begin
                mout = mq.pop_front(); mtick = 1'b1; mrec++; mticks = 0; mmode = 2;
            end
        end else if (ce && mmode == 2) begin
            mticks++;
            if (mticks == SD) begin
                mticks = 0;
                if (can_pop) begin
                    mout = mq.pop_front(); mtick = 1'b1; mrec++;
                end else begin
                    if (munder < 65535) munder++;
                    mmode = 3;
                end
            end
        end
        if (acc) mq.push_back(d);
    endtask

    initial begin
        nom = {W'(823), W'(643), W'(514), W'(354), W'(199)};
        rst_n = 1'b0; clk_en = 1'b0; enable = 1'b0; rec_valid = 1'b0; rec_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_omega", omega_dt_packed, nom);
        check("reset_ready", rec_ready, 1'b1);
        check("reset_playing", playing, 1'b0);
        check("reset_tick", frame_tick, 1'b0);
        check("reset_underrun", underrun_count, 16'd0);
        check("reset_records", record_count, 32'd0);

        //               en    ce    v     rid ready tick  play  h0
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 199});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 199});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 199});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 199});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 199});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 199});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1001});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1001});
        for (int r = 2; r <= 5; r++) begin
            for (int k = 0; k < 3; k++) tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1000 + r - 1});
            if (r <= 4) tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1000 + r});
            else        tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1004});
        end
        tbl.push_back('{1'b1, 1'b0, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1004});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1006});

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            enable = tbl[i].en; clk_en = tbl[i].ce; rec_valid = tbl[i].v; rec_data = rec(tbl[i].rid);
            #1 check($sformatf("vec%0d_ready", i), rec_ready, tbl[i].ready);
            @(posedge clk); #1;
            check($sformatf("vec%0d_tick", i), frame_tick, tbl[i].tick);
            check($sformatf("vec%0d_playing", i), playing, tbl[i].play);
            check($sformatf("vec%0d_h0", i), omega_dt_packed[W-1:0], W'(tbl[i].h0));
        end
        check("table_records", record_count, 32'd5);
        check("table_underrun", underrun_count, 16'd1);
        check("table_omega", omega_dt_packed, rec(6));

        // Disable mid-frame at div_cnt=2, then resume from the retained FIFO.
        @(negedge clk); clk_en = 1'b0; rec_valid = 1'b1; rec_data = rec(7);
        @(negedge clk); rec_data = rec(8);
        @(negedge clk); rec_valid = 1'b0; clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk); clk_en = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("dis_playing", playing, 1'b0);
        check("dis_omega", omega_dt_packed, rec(6));
        check("dis_ready", rec_ready, 1'b1);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("dis_hold_omega", omega_dt_packed, rec(6));
        check("dis_hold_records", record_count, 32'd5);
        clk_en = 1'b0; enable = 1'b1;
        @(negedge clk); clk_en = 1'b1;
        @(negedge clk); clk_en = 1'b0;
        check("resume_omega", omega_dt_packed, rec(7));
        check("resume_tick", frame_tick, 1'b1);
        check("resume_playing", playing, 1'b1);
        check("resume_records", record_count, 32'd6);

        // Asynchronous reset in the middle of a clock high phase.
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("areset_omega", omega_dt_packed, nom);
        check("areset_playing", playing, 1'b0);
        check("areset_records", record_count, 32'd0);
        check("areset_underrun", underrun_count, 16'd0);
        @(negedge clk); rst_n = 1'b1; enable = 1'b1;
        @(negedge clk); clk_en = 1'b1;
        @(negedge clk); clk_en = 1'b0;
        check("areset_empty_tick", frame_tick, 1'b0);
        check("areset_empty_omega", omega_dt_packed, nom);
        check("areset_empty_playing", playing, 1'b0);

        // Randomized run against the queue model.
        enable = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mq.delete(); mmode = 0; mticks = 0; mout = nom; mtick = 1'b0; munder = 0; mrec = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            logic en_v, ce_v, v_v;
            logic [DW-1:0] d_v;
            @(negedge clk);
            check("rnd_omega", omega_dt_packed, mout);
            check("rnd_tick", frame_tick, mtick);
            check("rnd_playing", playing, (mmode == 2));
            check("rnd_underrun", underrun_count, 16'(munder));
            check("rnd_records", record_count, mrec);
            check("rnd_ready", rec_ready, (mq.size() < DEPTH));
            en_v = enable;
            if (enable && $urandom_range(0, 59) == 0) en_v = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) en_v = 1'b1;
            ce_v = ($urandom_range(0, 2) == 0);
            v_v  = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            d_v  = {W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
            enable = en_v; clk_en = ce_v; rec_valid = v_v; rec_data = d_v;
            model_step(en_v, ce_v, v_v, d_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_param_playback.md
Name: sr_param_playback

Overview:
- Replays recorded Schumann-resonance frequency records into the live oscillator bank. It is the consumer counterpart of the 1 Hz record logger.
- Accepts packed 5-harmonic omega_dt records over a valid/ready stream and buffers them in a small FIFO.
- Applies one record every SAMPLE_DIVISOR clk_en pulses. The output is a drop-in replacement for the drift generator's omega_dt_packed feeding the Hopf oscillators.

Parameters:
- WIDTH, 18, signed Q14 word width per harmonic
- SAMPLE_DIVISOR, 4000, clk_en pulses per record (4000 = 1 record/s at 4 kHz)
- FIFO_DEPTH, 4, record buffer depth; power of two, minimum 2
- NOM_F0..NOM_F4, 199/354/514/643/823, reset omega_dt per harmonic
- SLEW_STEP, 1, max LSB change per clk_en (used only with the optional feature)

Ports:
- clk  in  1  system clock (125 MHz)
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  4 kHz update strobe, one cycle wide
- enable  in  1  playback run control
- rec_valid  in  1  record offered
- rec_ready  out  1  record accepted when rec_valid && rec_ready
- rec_data  in  5*WIDTH  packed record, harmonic 0 in bits [WIDTH-1:0]
- omega_dt_packed  out  5*WIDTH  applied omega_dt, same packing as rec_data
- frame_tick  out  1  one-cycle pulse on the cycle a record is applied
- playing  out  1  high in PLAY
- underrun_count  out  16  saturating count of missed records
- record_count  out  32  records applied, wraps at 2^32

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empties; state goes to IDLE; div_cnt clears to 0.
  - omega_dt_packed = {NOM_F4,…,NOM_F0}.
  - frame_tick=0, playing=0, both counters 0.
- rec_ready = !full, combinational from the registered FIFO count. It is 1 immediately after reset.
- Push/pop rules:
  - A push is registered in the same cycle.
  - Push while full is impossible, because ready is low.
  - Simultaneous push and pop while full: the push is rejected, since ready reflects the pre-pop state.
  - No bypass: a record pushed in cycle N can be popped at the earliest in cycle N+1.
- Apply: pop the head record and register it into omega_dt_packed (visible the cycle after the clk_en cycle). frame_tick is asserted that same registered cycle, and record_count increments.
- FSM states: IDLE, PRIME, PLAY, HOLD. All transitions except the enable check occur only on cycles with clk_en=1.
  - IDLE: outputs hold. Go to PRIME when enable=1.
  - PRIME: if FIFO non-empty, apply, set div_cnt=0, go to PLAY. Otherwise stay.
  - PLAY:
    - Each clk_en increments div_cnt.
    - At div_cnt==SAMPLE_DIVISOR-1: div_cnt becomes 0.
    - If non-empty, apply and stay in PLAY.
    - If empty, increment underrun_count (saturating at 16'hFFFF), go to HOLD, and outputs hold their last values.
  - HOLD: on the first clk_en with FIFO non-empty, apply, set div_cnt=0, go to PLAY. This resynchronises the frame phase to the late record.
- enable=0 in any state: go to IDLE on the next clk (clk_en not required) and clear div_cnt. FIFO contents and outputs are retained, and the FIFO keeps accepting records.
- enable re-asserted: IDLE → PRIME, so the first buffered record applies on the next clk_en.
- clk_en while rst_n low is ignored.
- div_cnt is wide enough for SAMPLE_DIVISOR-1 and never exceeds it.

Optional Feature:
- Macro: SR_PLAYBACK_SLEW_EN
- Defined:
  - An applied record loads internal target registers instead of the outputs.
  - On every clk_en, each harmonic of omega_dt_packed moves toward its target by min(|target−current|, SLEW_STEP), using signed compare.
  - frame_tick still marks the load.
  - Targets reset to the NOM values.
- Undefined: the record is written directly to omega_dt_packed, with no target registers.

Test Plan:
- Reset, then check idle state: after rst_n rises, expect omega_dt_packed={823,643,514,354,199}, rec_ready=1, playing=0, counters 0.
- Fill FIFO, then check backpressure: with SAMPLE_DIVISOR=4 and FIFO_DEPTH=4, push 5 records back-to-back with enable=0. Expect 4 accepted, rec_ready=0 on the 5th, and no output change.
- Steady playback: enable=1 with 3 records buffered. Expect the first applied on the first clk_en. Expect further records exactly 4 clk_en apart, a frame_tick per record, and record_count=3.
- Underrun and recover: buffer one record and play past the next frame boundary. Expect underrun_count=1, playing=0, outputs held. Push a record; expect it applied on the next clk_en and playing=1.
- Disable and reset mid-frame: deassert enable at div_cnt=2. Expect IDLE with outputs and FIFO retained. Pull rst_n low asynchronously mid-clk; expect immediate NOM outputs and an empty FIFO.
- Slew (macro defined, SLEW_STEP=1): start from 199 and apply a record with harmonic 0 = 202. Expect 200, 201, 202 on successive clk_en, then stable.
